// File: rtl/ysyx_23060042_lsu_if.sv
// Data-memory bus between the LSU and memory: one request channel with a
// valid/ready handshake, and one response channel with no backpressure.
interface ysyx_23060042_lsu_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        mem_resp_err;

    modport master (
        output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        input  mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );

    modport slave (
        input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
        output mem_req_ready, mem_resp_valid, mem_rdata, mem_resp_err
    );
endinterface

// File: rtl/ysyx_23060042_lsu.sv
// Load/store unit: one operation in flight, word-aligned bus request, lane extract/extend.
// Optional alignment check enabled by defining YSYX_23060042_LSU_ALIGN_CHECK_EN.
module ysyx_23060042_lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    ysyx_23060042_lsu_if.master mem
);
    // One extra count of headroom: a late REQ->WAIT hop at the limit must not wrap.
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          load_q, load_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic          misal;
    logic          tmo;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   ld_ext;
    logic [31:0]   st_data;
    logic [3:0]    st_mask;

`ifdef YSYX_23060042_LSU_ALIGN_CHECK_EN
    assign misal = (in_size == 2'b01 && in_addr[0]) ||
                   (in_size == 2'b10 && in_addr[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    assign tmo = cnt_q >= CW'(TIMEOUT);

    assign ld_byte = 8'(mem.mem_rdata >> {addr_q[1:0], 3'b000});
    assign ld_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

    always_comb begin
        ld_ext = mem.mem_rdata;
        case (size_q)
            2'b00:   ld_ext = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            2'b01:   ld_ext = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: ld_ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        st_data = wdata_q;
        st_mask = 4'b0000;
        case (size_q)
            2'b00: begin
                st_data = {4{wdata_q[7:0]}};
                st_mask = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                st_data = {2{wdata_q[15:0]}};
                st_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_data = wdata_q;
                st_mask = 4'b1111;
            end
        endcase
        if (load_q) st_mask = 4'b0000;
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        load_d  = load_q;
        size_d  = size_q;
        uns_d   = uns_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    addr_d  = in_addr;
                    wdata_d = in_wdata;
                    load_d  = in_load;
                    size_d  = in_size;
                    uns_d   = in_unsigned;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    if (!in_load && !in_store) begin
                        state_d = RESP;
                    end else if ((in_load && in_store) || in_size == 2'b11 || misal) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 1'b1;
                if (mem.mem_req_ready) begin
                    state_d = WAIT;
                end else if (tmo) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A response in the timeout cycle still completes normally.
                if (mem.mem_resp_valid) begin
                    state_d = RESP;
                    err_d   = mem.mem_resp_err;
                    if (load_q) rdata_d = ld_ext;
                end else if (tmo) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            load_q  <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            load_q  <= load_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus and result outputs are gated by state so idle values are all zero.
    assign in_ready          = state_q == IDLE;
    assign out_valid         = state_q == RESP;
    assign out_rdata         = out_valid ? rdata_q : 32'h0;
    assign out_err           = out_valid & err_q;
    assign mem.mem_req_valid = state_q == REQ;
    assign mem.mem_addr      = mem.mem_req_valid ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem.mem_wen       = mem.mem_req_valid & ~load_q;
    assign mem.mem_wdata     = (mem.mem_req_valid && !load_q) ? st_data : 32'h0;
    assign mem.mem_wmask     = mem.mem_req_valid ? st_mask : 4'b0000;
endmodule

// File: tb/tb_ysyx_23060042_lsu.sv
// Directed bench for ysyx_23060042_lsu with hand-computed expectations.
module tb_ysyx_23060042_lsu;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_wdata = '0;
    logic        in_load = 1'b0;
    logic        in_store = 1'b0;
    logic [1:0]  in_size = '0;
    logic        in_unsigned = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic        out_err;

    int total = 0;
    int bad   = 0;

    ysyx_23060042_lsu_if mem_bus();

    ysyx_23060042_lsu #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_wdata(in_wdata),
        .in_load(in_load), .in_store(in_store),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rdata(out_rdata), .out_err(out_err),
        .mem(mem_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation for a single accepted cycle; returns in cycle N+1.
    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic ld,
                         input logic st, input logic [1:0] sz, input logic un);
        in_valid = 1'b1; in_addr = a; in_wdata = d;
        in_load = ld; in_store = st; in_size = sz; in_unsigned = un;
        step();
        in_valid = 1'b0; in_addr = '0; in_wdata = '0;
        in_load = 1'b0; in_store = 1'b0; in_size = '0; in_unsigned = 1'b0;
    endtask

    // From N+1: ready at once, response one cycle later; returns in N+3.
    task automatic mem_xfer(input logic [31:0] rd, input logic e);
        mem_bus.mem_req_ready = 1'b1;
        step();
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_rdata = rd; mem_bus.mem_resp_err = e;
        step();
        mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_rdata = '0; mem_bus.mem_resp_err = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("drain_idle", {30'b0, out_valid, in_ready}, 32'h1);
    endtask

    initial begin
        mem_bus.mem_req_ready = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_rdata = '0;
        mem_bus.mem_resp_err = 1'b0;
        step(); step();
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_req_valid", {31'b0, mem_bus.mem_req_valid}, 32'h0);
        chk("rst_wmask", {28'b0, mem_bus.mem_wmask}, 32'h0);
        rst = 1'b1;
        step();

        // word store
        issue(32'h8000_0004, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'b10, 1'b0);
        chk("sw_req_valid", {31'b0, mem_bus.mem_req_valid}, 32'h1);
        chk("sw_in_ready", {31'b0, in_ready}, 32'h0);
        chk("sw_addr", mem_bus.mem_addr, 32'h8000_0004);
        chk("sw_wmask", {28'b0, mem_bus.mem_wmask}, 32'hF);
        chk("sw_wen", {31'b0, mem_bus.mem_wen}, 32'h1);
        chk("sw_wdata", mem_bus.mem_wdata, 32'hDEAD_BEEF);
        mem_xfer(32'h0, 1'b0);
        chk("sw_out_valid", {31'b0, out_valid}, 32'h1);
        chk("sw_out_err", {31'b0, out_err}, 32'h0);
        chk("sw_out_rdata", out_rdata, 32'h0);
        drain();

        // signed byte load, lane 3
        issue(32'h8000_0003, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0);
        chk("lb_addr", mem_bus.mem_addr, 32'h8000_0000);
        chk("lb_wmask", {28'b0, mem_bus.mem_wmask}, 32'h0);
        chk("lb_wen", {31'b0, mem_bus.mem_wen}, 32'h0);
        mem_xfer(32'h80FF_1234, 1'b0);
        chk("lb_out_valid", {31'b0, out_valid}, 32'h1);
        chk("lb_rdata", out_rdata, 32'hFFFF_FF80);
        drain();

        // unsigned byte load, lane 3
        issue(32'h8000_0003, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1);
        mem_xfer(32'h80FF_1234, 1'b0);
        chk("lbu_rdata", out_rdata, 32'h0000_0080);
        drain();

        // signed half load, upper half
        issue(32'h8000_0002, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0);
        mem_xfer(32'h8001_7FFF, 1'b0);
        chk("lh_rdata", out_rdata, 32'hFFFF_8001);
        drain();

        // half store upper lane
        issue(32'h8000_0002, 32'h1234_ABCD, 1'b0, 1'b1, 2'b01, 1'b0);
        chk("sh_wdata", mem_bus.mem_wdata, 32'hABCD_ABCD);
        chk("sh_wmask", {28'b0, mem_bus.mem_wmask}, 32'hC);
        chk("sh_addr", mem_bus.mem_addr, 32'h8000_0000);
        mem_xfer(32'h0, 1'b0);
        drain();

        // byte store lane 1
        issue(32'h8000_0001, 32'h0000_005A, 1'b0, 1'b1, 2'b00, 1'b0);
        chk("sb_wdata", mem_bus.mem_wdata, 32'h5A5A_5A5A);
        chk("sb_wmask", {28'b0, mem_bus.mem_wmask}, 32'h2);
        mem_xfer(32'h0, 1'b0);
        drain();

        // bus error on load
        issue(32'h8000_0010, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        mem_xfer(32'hCAFE_F00D, 1'b1);
        chk("buserr_err", {31'b0, out_err}, 32'h1);
        drain();

        // timeout: memory never answers
        issue(32'h8000_0000, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        chk("tmo_req_rise", {31'b0, mem_bus.mem_req_valid}, 32'h1);
        for (int i = 1; i <= TMO; i++) begin
            step();
            chk($sformatf("tmo_wait%0d", i), {30'b0, out_valid, mem_bus.mem_req_valid}, 32'h1);
        end
        step();
        chk("tmo_out_valid", {31'b0, out_valid}, 32'h1);
        chk("tmo_err", {31'b0, out_err}, 32'h1);
        chk("tmo_req_drop", {31'b0, mem_bus.mem_req_valid}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("tmo_hold%0d", i), {30'b0, out_valid, out_err}, 32'h3);
        end
        drain();

        // word load at a misaligned address
        issue(32'h8000_0002, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
`ifdef YSYX_23060042_LSU_ALIGN_CHECK_EN
        chk("lw_mis_req", {31'b0, mem_bus.mem_req_valid}, 32'h0);
        chk("lw_mis_err", {30'b0, out_valid, out_err}, 32'h3);
`else
        chk("lw_mis_addr", mem_bus.mem_addr, 32'h8000_0000);
        mem_xfer(32'h1122_3344, 1'b0);
        chk("lw_mis_rdata", out_rdata, 32'h1122_3344);
        chk("lw_mis_err", {31'b0, out_err}, 32'h0);
`endif
        drain();

        // no-op, load+store, reserved size: immediate result
        issue(32'h8000_0000, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
        chk("nop_out", {30'b0, out_valid, out_err}, 32'h2);
        chk("nop_req", {31'b0, mem_bus.mem_req_valid}, 32'h0);
        drain();
        issue(32'h8000_0000, 32'h0, 1'b1, 1'b1, 2'b10, 1'b0);
        chk("ldst_out", {30'b0, out_valid, out_err}, 32'h3);
        drain();
        issue(32'h8000_0000, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0);
        chk("rsvd_out", {30'b0, out_valid, out_err}, 32'h3);
        drain();

        // reset during WAIT, then a stale response
        issue(32'h8000_0008, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
        mem_bus.mem_req_ready = 1'b1;
        step();
        mem_bus.mem_req_ready = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_rdata = 32'h5555_AAAA;
        step();
        mem_bus.mem_resp_valid = 1'b0; mem_bus.mem_rdata = '0;
        chk("rstw_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rstw_out", {30'b0, out_valid, out_err}, 32'h0);
        chk("rstw_rdata", out_rdata, 32'h0);
        chk("rstw_req", {31'b0, mem_bus.mem_req_valid}, 32'h0);
        step();
        chk("rstw_no_pulse", {31'b0, out_valid}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ysyx_23060042_lsu.md
# ysyx_23060042_lsu

Load/store unit between the execute stage and the data-memory port. It accepts one memory operation at a time: an address computed by the ALU, store data, size and sign-extension control. It issues a single word-aligned request on a valid/ready memory bus with byte lanes and strobes, and returns the lane-extracted, sign- or zero-extended load result as the `mrdata` value consumed by the execute stage's write-back mux. A response timeout and (optionally) an alignment check report errors instead of hanging the core.

## Interface
Parameters:
- `TIMEOUT`, default 255: cycles allowed from request issue to memory response before an error is reported; must be ≥ 1.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  core clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset
- `in_valid`  in  1  upstream operation valid
- `in_ready`  out  1  unit can accept an operation
- `in_addr`  in  32  byte address
- `in_wdata`  in  32  store data, right-aligned
- `in_load`  in  1  operation is a load
- `in_store`  in  1  operation is a store
- `in_size`  in  2  00 byte, 01 half, 10 word, 11 reserved
- `in_unsigned`  in  1  zero-extend load result (else sign-extend)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  downstream accepts result
- `out_rdata`  out  32  extended load data (0 for stores)
- `out_err`  out  1  operation failed (reserved size, load+store, misaligned, timeout, bus error)
- `mem_req_valid`  out  1  memory request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_addr`  out  32  word-aligned address ({addr[31:2],2'b00})
- `mem_wen`  out  1  request is a write
- `mem_wdata`  out  32  lane-replicated store data
- `mem_wmask`  out  4  byte strobes
- `mem_resp_valid`  in  1  response valid (no backpressure)
- `mem_rdata`  in  32  full read word
- `mem_resp_err`  in  1  bus error with response

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: `in_ready`=1. On `in_valid`, latch all `in_*` fields, then:
  - neither load nor store → RESP, rdata 0, err 0;
  - both set, or size 11 → RESP, err 1;
  - misaligned when the alignment check is enabled (see Configuration) → RESP, err 1;
  - otherwise → REQ and clear the timeout counter.
- REQ: `mem_req_valid`=1, with address, data and mask held stable. On `mem_req_ready` → WAIT.
- WAIT: on `mem_resp_valid` → RESP, `out_err`=`mem_resp_err`; for loads, capture extracted data.
- Counter increments each cycle in REQ and WAIT. If it reaches `TIMEOUT` with no transition → RESP, err 1, and `mem_req_valid` deasserts. A response arriving in the same cycle wins over the timeout.
- RESP: `out_valid`=1, with `out_rdata`/`out_err` stable. On `out_ready` → IDLE.
- Load extraction uses lane = `addr[1:0]`:
  - byte: `mem_rdata[8*lane+:8]`;
  - half: `mem_rdata[16*addr[1]+:16]`;
  - word: unchanged;
  - extend from bit 7/15 unless `in_unsigned`.
- Stores:
  - byte: `mem_wdata`={4{b}}, `mem_wmask`=0001<<lane;
  - half: {2{h}}, 0011<<(2*addr[1]);
  - word: 1111.
  - Loads drive `mem_wmask`=0 and `mem_wen`=0.
- Memory responses in IDLE, REQ or RESP are ignored.

## Timing
- Reset value of every output is 0, except `in_ready`=1; state is IDLE and the counter is 0.
- Reset asserted mid-operation aborts the operation with no output pulse. An outstanding memory response after reset is ignored.
- Best-case latency: accept at cycle N, `mem_req_valid` at N+1. With ready and response both in N+1 → the response must come at ≥ N+2, so `out_valid` at N+3.
- Error or no-op path: `out_valid` at N+1.
- Only one operation is in flight; `in_ready`=0 outside IDLE. Result is held until `out_ready`.
- Timeout: `out_valid` asserts exactly `TIMEOUT`+1 cycles after `mem_req_valid` first rises.

## Configuration
- `YSYX_23060042_LSU_ALIGN_CHECK_EN` defined: half at odd address or word with `addr[1:0]`≠0 → no memory request, RESP with err 1.
- Undefined: no check. Half uses lane `addr[1]` (ignores `addr[0]`); word ignores `addr[1:0]`.

## Test plan
- Word store 0xDEADBEEF to 0x80000004, memory ready at once, response 1 cycle later → `mem_addr`=0x80000004, `mem_wmask`=1111, `out_valid` 3 cycles after accept, `out_err`=0.
- Byte load at 0x80000003, `mem_rdata`=0x80FF1234 → signed `out_rdata`=0xFFFFFF80; unsigned 0x00000080.
- Half store 0xABCD at 0x80000002 → `mem_wdata`=0xABCDABCD, `mem_wmask`=1100.
- Memory never responds, `TIMEOUT`=4 → `out_err`=1 five cycles after `mem_req_valid` rises; hold `out_ready`=0 for 3 cycles → outputs stable.
- Word load at 0x80000002: with macro → err 1 and no `mem_req_valid`; without → `mem_addr`=0x80000000, data returned.
- `rst`=0 asserted during WAIT, then a late `mem_resp_valid` arrives → all outputs 0 and `in_ready`=1; no `out_valid` pulse.
